axi3_master_port: RTL and testbench

- AXI3 master-side port engine. Converts simple valid/ready command and data streams from the user into AXI3 handshakes on the AW, W, B, AR and R channels, with master-side signal directions.
- Sits between the master-VIP driver logic and the AXI bus.
- Allows one outstanding write and one outstanding read; the two paths run independently.

---
 rtl/axi3_master_port.sv | 373 +++++++++++++++++++++++++++++++++++++
 tb/tb_axi3_master_port.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_master_port.sv
// axi3_master_port: AXI3 master-side port engine.
// Turns user valid/ready command and data streams into AXI3 AW/W/B and AR/R
// handshakes. One write and one read may be outstanding at a time, and the
// two paths run independently.
// Optional build macro AXI_MAS_LEN_CHK_EN: enables the sticky read-length
// checker that drives len_err. Without it, len_err is tied low.
// DATA_WIDTH must be a power of 2 and at least 8.

module axi3_master_port #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int SIZE_WIDTH = 3
) (
  input  logic                    aclk,
  input  logic                    arst,

  // User write command
  input  logic                    wr_cmd_valid,
  output logic                    wr_cmd_ready,
  input  logic [ID_WIDTH-1:0]     wr_cmd_id,
  input  logic [ADDR_WIDTH-1:0]   wr_cmd_addr,
  input  logic [LEN_WIDTH-1:0]    wr_cmd_len,
  input  logic [SIZE_WIDTH-1:0]   wr_cmd_size,
  input  logic [1:0]              wr_cmd_burst,

  // User write data
  input  logic                    wr_dat_valid,
  output logic                    wr_dat_ready,
  input  logic [DATA_WIDTH-1:0]   wr_dat_data,
  input  logic [DATA_WIDTH/8-1:0] wr_dat_strb,

  // User write response
  output logic                    wr_rsp_valid,
  input  logic                    wr_rsp_ready,
  output logic [ID_WIDTH-1:0]     wr_rsp_id,
  output logic [1:0]              wr_rsp_resp,

  // User read command
  input  logic                    rd_cmd_valid,
  output logic                    rd_cmd_ready,
  input  logic [ID_WIDTH-1:0]     rd_cmd_id,
  input  logic [ADDR_WIDTH-1:0]   rd_cmd_addr,
  input  logic [LEN_WIDTH-1:0]    rd_cmd_len,
  input  logic [SIZE_WIDTH-1:0]   rd_cmd_size,
  input  logic [1:0]              rd_cmd_burst,

  // User read data
  output logic                    rd_dat_valid,
  input  logic                    rd_dat_ready,
  output logic [DATA_WIDTH-1:0]   rd_dat_data,
  output logic [1:0]              rd_dat_resp,
  output logic                    rd_dat_last,
  output logic [ID_WIDTH-1:0]     rd_dat_id,

  // AXI3 write address channel
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [LEN_WIDTH-1:0]    awlen,
  output logic [SIZE_WIDTH-1:0]   awsize,
  output logic [1:0]              awbrust,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,

  // AXI3 write data channel
  output logic [ID_WIDTH-1:0]     wid,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrob,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,

  // AXI3 write response channel
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,

  // AXI3 read address channel
  output logic [ID_WIDTH-1:0]     arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [LEN_WIDTH-1:0]    arlen,
  output logic [SIZE_WIDTH-1:0]   arsize,
  output logic [1:0]              arbrust,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,

  // AXI3 read data channel
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,

  // Sticky read-length error
  output logic                    len_err
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA}         r_state_e;

  // Address-phase payload shared by AW and AR.
  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [SIZE_WIDTH-1:0] size;
    logic [1:0]            burst;
  } addr_cmd_t;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_e              w_state_q,      w_state_d;
  addr_cmd_t             aw_q,           aw_d;
  logic                  awvalid_q,      awvalid_d;
  logic [ID_WIDTH-1:0]   wid_q,          wid_d;
  logic [DATA_WIDTH-1:0] wdata_q,        wdata_d;
  logic [STRB_WIDTH-1:0] wstrob_q,       wstrob_d;
  logic                  wlast_q,        wlast_d;
  logic                  wvalid_q,       wvalid_d;
  logic [LEN_WIDTH-1:0]  w_cnt_q,        w_cnt_d;
  logic                  wr_rsp_valid_q, wr_rsp_valid_d;
  logic [ID_WIDTH-1:0]   wr_rsp_id_q,    wr_rsp_id_d;
  logic [1:0]            wr_rsp_resp_q,  wr_rsp_resp_d;

  // Write-path state and payload registers.
  always_ff @(posedge aclk) begin
    // NOTE: every register here uses <= so all flops update from the same
    // pre-edge values; a blocking = would let later lines see new values.
    if (arst) begin
      w_state_q      <= W_IDLE;
      aw_q           <= '0;
      awvalid_q      <= 1'b0;
      wid_q          <= '0;
      wdata_q        <= '0;
      wstrob_q       <= '0;
      wlast_q        <= 1'b0;
      wvalid_q       <= 1'b0;
      w_cnt_q        <= '0;
      wr_rsp_valid_q <= 1'b0;
      wr_rsp_id_q    <= '0;
      wr_rsp_resp_q  <= '0;
    end else begin
      w_state_q      <= w_state_d;
      aw_q           <= aw_d;
      awvalid_q      <= awvalid_d;
      wid_q          <= wid_d;
      wdata_q        <= wdata_d;
      wstrob_q       <= wstrob_d;
      wlast_q        <= wlast_d;
      wvalid_q       <= wvalid_d;
      w_cnt_q        <= w_cnt_d;
      wr_rsp_valid_q <= wr_rsp_valid_d;
      wr_rsp_id_q    <= wr_rsp_id_d;
      wr_rsp_resp_q  <= wr_rsp_resp_d;
    end
  end

  // Write FSM: next state, next payload and the user/bus ready strobes.
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so
    // no path leaves a signal unassigned and no latch is inferred.
    w_state_d      = w_state_q;
    aw_d           = aw_q;
    awvalid_d      = awvalid_q;
    wid_d          = wid_q;
    wdata_d        = wdata_q;
    wstrob_d       = wstrob_q;
    wlast_d        = wlast_q;
    wvalid_d       = wvalid_q;
    w_cnt_d        = w_cnt_q;
    wr_rsp_valid_d = wr_rsp_valid_q;
    wr_rsp_id_d    = wr_rsp_id_q;
    wr_rsp_resp_d  = wr_rsp_resp_q;
    wr_cmd_ready   = 1'b0;
    wr_dat_ready   = 1'b0;
    bready         = 1'b0;

    unique case (w_state_q)
      W_IDLE: begin
        wr_cmd_ready = 1'b1;
        if (wr_cmd_valid) begin
          aw_d      = '{id: wr_cmd_id, addr: wr_cmd_addr, len: wr_cmd_len,
                        size: wr_cmd_size, burst: wr_cmd_burst};
          wid_d     = wr_cmd_id;
          awvalid_d = 1'b1;
          w_state_d = W_ADDR;
        end
      end

      W_ADDR: begin
        if (awready) begin
          awvalid_d = 1'b0;
          w_cnt_d   = '0;
          w_state_d = W_DATA;
        end
      end

      W_DATA: begin
        // The skid slot is free when empty or draining this cycle. Once the
        // last beat is loaded, no further user beat belongs to this burst.
        wr_dat_ready = !wvalid_q || (wready && !wlast_q);
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
        end
        if (wr_dat_valid && wr_dat_ready) begin
          wdata_d  = wr_dat_data;
          wstrob_d = wr_dat_strb;
          wlast_d  = (w_cnt_q == aw_q.len);
          wvalid_d = 1'b1;
          w_cnt_d  = w_cnt_q + LEN_WIDTH'(1);
        end
        if (wvalid_q && wready && wlast_q) begin
          w_state_d = W_RESP;
        end
      end

      W_RESP: begin
        bready = !wr_rsp_valid_q;
        if (bvalid && !wr_rsp_valid_q) begin
          wr_rsp_id_d    = bid;
          wr_rsp_resp_d  = bresp;
          wr_rsp_valid_d = 1'b1;
        end
        if (wr_rsp_valid_q && wr_rsp_ready) begin
          wr_rsp_valid_d = 1'b0;
          w_state_d      = W_IDLE;
        end
      end

      default: w_state_d = W_IDLE;
    endcase
  end

  assign awid         = aw_q.id;
  assign awaddr       = aw_q.addr;
  assign awlen        = aw_q.len;
  assign awsize       = aw_q.size;
  assign awbrust      = aw_q.burst;
  assign awlock       = 2'b00;
  assign awcache      = 4'b0000;
  assign awprot       = 3'b000;
  assign awvalid      = awvalid_q;
  assign wid          = wid_q;
  assign wdata        = wdata_q;
  assign wstrob       = wstrob_q;
  assign wlast        = wlast_q;
  assign wvalid       = wvalid_q;
  assign wr_rsp_valid = wr_rsp_valid_q;
  assign wr_rsp_id    = wr_rsp_id_q;
  assign wr_rsp_resp  = wr_rsp_resp_q;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_e  r_state_q, r_state_d;
  addr_cmd_t ar_q,      ar_d;
  logic      arvalid_q, arvalid_d;

`ifdef AXI_MAS_LEN_CHK_EN
  logic [LEN_WIDTH-1:0] r_cnt_q,   r_cnt_d;
  logic                 len_err_q, len_err_d;
`endif

  // Read-path state and payload registers.
  always_ff @(posedge aclk) begin
    if (arst) begin
      r_state_q <= R_IDLE;
      ar_q      <= '0;
      arvalid_q <= 1'b0;
`ifdef AXI_MAS_LEN_CHK_EN
      r_cnt_q   <= '0;
      len_err_q <= 1'b0;
`endif
    end else begin
      r_state_q <= r_state_d;
      ar_q      <= ar_d;
      arvalid_q <= arvalid_d;
`ifdef AXI_MAS_LEN_CHK_EN
      r_cnt_q   <= r_cnt_d;
      len_err_q <= len_err_d;
`endif
    end
  end

  // Read FSM: address phase, then R beats pass straight through to the user.
  always_comb begin
    r_state_d    = r_state_q;
    ar_d         = ar_q;
    arvalid_d    = arvalid_q;
    rd_cmd_ready = 1'b0;
    rd_dat_valid = 1'b0;
    rready       = 1'b0;
`ifdef AXI_MAS_LEN_CHK_EN
    r_cnt_d      = r_cnt_q;
    len_err_d    = len_err_q;
`endif

    unique case (r_state_q)
      R_IDLE: begin
        rd_cmd_ready = 1'b1;
        if (rd_cmd_valid) begin
          ar_d      = '{id: rd_cmd_id, addr: rd_cmd_addr, len: rd_cmd_len,
                        size: rd_cmd_size, burst: rd_cmd_burst};
          arvalid_d = 1'b1;
          r_state_d = R_ADDR;
        end
      end

      R_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
`ifdef AXI_MAS_LEN_CHK_EN
          r_cnt_d   = '0;
`endif
          r_state_d = R_DATA;
        end
      end

      R_DATA: begin
        rd_dat_valid = rvalid;
        rready       = rd_dat_ready;
        if (rvalid && rd_dat_ready) begin
`ifdef AXI_MAS_LEN_CHK_EN
          r_cnt_d = r_cnt_q + LEN_WIDTH'(1);
          // Early rlast, or the final expected beat arriving without rlast.
          if ((rlast && (r_cnt_q != ar_q.len)) ||
              (!rlast && (r_cnt_q == ar_q.len))) begin
            len_err_d = 1'b1;
          end
`endif
          if (rlast) begin
            r_state_d = R_IDLE;
          end
        end
      end

      default: r_state_d = R_IDLE;
    endcase
  end

  assign arid        = ar_q.id;
  assign araddr      = ar_q.addr;
  assign arlen       = ar_q.len;
  assign arsize      = ar_q.size;
  assign arbrust     = ar_q.burst;
  assign arlock      = 2'b00;
  assign arcache     = 4'b0000;
  assign arprot      = 3'b000;
  assign arvalid     = arvalid_q;
  assign rd_dat_data = rdata;
  assign rd_dat_resp = rresp;
  assign rd_dat_last = rlast;
  assign rd_dat_id   = rid;

`ifdef AXI_MAS_LEN_CHK_EN
  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi3_master_port.sv
// Directed testbench for axi3_master_port: reset, single write with delayed
// awready, 4-beat write with toggling wready, 8-beat read with a stalled
// user, concurrent write/read, and a short read burst for the length checker.

module tb_axi3_master_port;

  logic        aclk = 1'b0;
  logic        arst;
  logic        wr_cmd_valid, wr_cmd_ready;
  logic [3:0]  wr_cmd_id;
  logic [31:0] wr_cmd_addr;
  logic [3:0]  wr_cmd_len;
  logic [2:0]  wr_cmd_size;
  logic [1:0]  wr_cmd_burst;
  logic        wr_dat_valid, wr_dat_ready;
  logic [31:0] wr_dat_data;
  logic [3:0]  wr_dat_strb;
  logic        wr_rsp_valid, wr_rsp_ready;
  logic [3:0]  wr_rsp_id;
  logic [1:0]  wr_rsp_resp;
  logic        rd_cmd_valid, rd_cmd_ready;
  logic [3:0]  rd_cmd_id;
  logic [31:0] rd_cmd_addr;
  logic [3:0]  rd_cmd_len;
  logic [2:0]  rd_cmd_size;
  logic [1:0]  rd_cmd_burst;
  logic        rd_dat_valid, rd_dat_ready;
  logic [31:0] rd_dat_data;
  logic [1:0]  rd_dat_resp;
  logic        rd_dat_last;
  logic [3:0]  rd_dat_id;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awbrust, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrob;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arbrust, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        len_err;

`ifdef AXI_MAS_LEN_CHK_EN
  localparam logic EXP_LEN_ERR = 1'b1;
`else
  localparam logic EXP_LEN_ERR = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int hs, beat, k;
  logic [31:0] w4_data [4] = '{32'h0102_0304, 32'h1122_3344, 32'hA5A5_5A5A, 32'hCAFE_F00D};

  always #5 aclk = ~aclk;

  axi3_master_port dut (
    .aclk(aclk), .arst(arst),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_id(wr_cmd_id),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len), .wr_cmd_size(wr_cmd_size),
    .wr_cmd_burst(wr_cmd_burst),
    .wr_dat_valid(wr_dat_valid), .wr_dat_ready(wr_dat_ready), .wr_dat_data(wr_dat_data),
    .wr_dat_strb(wr_dat_strb),
    .wr_rsp_valid(wr_rsp_valid), .wr_rsp_ready(wr_rsp_ready), .wr_rsp_id(wr_rsp_id),
    .wr_rsp_resp(wr_rsp_resp),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_id(rd_cmd_id),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len), .rd_cmd_size(rd_cmd_size),
    .rd_cmd_burst(rd_cmd_burst),
    .rd_dat_valid(rd_dat_valid), .rd_dat_ready(rd_dat_ready), .rd_dat_data(rd_dat_data),
    .rd_dat_resp(rd_dat_resp), .rd_dat_last(rd_dat_last), .rd_dat_id(rd_dat_id),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awbrust(awbrust),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrob(wstrob), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arbrust(arbrust),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .len_err(len_err)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; inputs are driven from here.
  task automatic clk1();
    @(posedge aclk);
    #1;
  endtask

  // Let combinational outputs settle after input changes, before sampling.
  task automatic settle();
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1;
    wr_cmd_valid = 0; wr_cmd_id = 0; wr_cmd_addr = 0; wr_cmd_len = 0; wr_cmd_size = 0; wr_cmd_burst = 0;
    wr_dat_valid = 0; wr_dat_data = 0; wr_dat_strb = 0; wr_rsp_ready = 0;
    rd_cmd_valid = 0; rd_cmd_id = 0; rd_cmd_addr = 0; rd_cmd_len = 0; rd_cmd_size = 0; rd_cmd_burst = 0;
    rd_dat_ready = 0;
    awready = 0; wready = 0; arready = 0;
    bid = 0; bresp = 0; bvalid = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;

    // ---- Reset with random B/R activity ----
    for (int i = 0; i < 3; i++) begin
      clk1();
      bvalid = 1'($urandom_range(0, 1)); bid = 4'($urandom); bresp = 2'($urandom);
      rvalid = 1'($urandom_range(0, 1)); rid = 4'($urandom); rdata = $urandom;
      rresp = 2'($urandom); rlast = 1'($urandom_range(0, 1));
    end
    rvalid = 1'b1;
    settle();
    check("rst_valids", {awvalid, wvalid, arvalid, wr_rsp_valid, len_err}, 5'b00000);
    check("rst_rd_gate", {rd_dat_valid, rready, bready}, 3'b000);
    arst = 1'b0; bvalid = 0; rvalid = 0; rlast = 0;
    clk1();
    settle();
    check("post_rst_valids", {awvalid, wvalid, arvalid, wr_rsp_valid, len_err}, 5'b00000);
    check("post_rst_cmd_ready", {wr_cmd_ready, rd_cmd_ready}, 2'b11);

    // ---- Single write, awready delayed 4 cycles ----
    wr_cmd_valid = 1; wr_cmd_id = 4'd3; wr_cmd_addr = 32'h1000; wr_cmd_len = 0;
    wr_cmd_size = 3'd2; wr_cmd_burst = 2'd1;
    settle();
    check("t1_cmd_ready", wr_cmd_ready, 1'b1);
    clk1();
    wr_cmd_valid = 0; wr_cmd_id = 4'hF; wr_cmd_addr = 32'hFFFF_FFFF; wr_cmd_len = 4'hF;
    settle();
    check("t1_aw_first", {awvalid, awid, awaddr, awlen, awsize, awbrust},
          {1'b1, 4'd3, 32'h1000, 4'd0, 3'd2, 2'd1});
    check("t1_cmd_busy", wr_cmd_ready, 1'b0);
    check("t1_aw_const", {awlock, awcache, awprot}, 9'd0);
    for (int i = 0; i < 4; i++) begin
      clk1();
      settle();
      check("t1_aw_stable", {awvalid, awid, awaddr, awlen, awsize, awbrust},
            {1'b1, 4'd3, 32'h1000, 4'd0, 3'd2, 2'd1});
    end
    awready = 1;
    clk1();
    awready = 0;
    settle();
    check("t1_aw_done", {awvalid, wvalid}, 2'b00);
    check("t1_wid", wid, 4'd3);
    check("t1_dat_ready", wr_dat_ready, 1'b1);
    wr_dat_valid = 1; wr_dat_data = 32'hDEAD_BEEF; wr_dat_strb = 4'hF;
    clk1();
    wr_dat_valid = 0; wr_dat_data = 32'h0; wr_dat_strb = 4'h0;
    settle();
    check("t1_w_beat", {wvalid, wlast, wstrob, wdata}, {1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF});
    check("t1_dat_stall", wr_dat_ready, 1'b0);
    clk1();
    settle();
    check("t1_w_hold", {wvalid, wlast, wstrob, wdata}, {1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF});
    wready = 1;
    clk1();
    wready = 0;
    settle();
    check("t1_w_done", wvalid, 1'b0);
    check("t1_bready", bready, 1'b1);
    bvalid = 1; bid = 4'd3; bresp = 2'd0;
    clk1();
    bvalid = 0; bid = 4'hF; bresp = 2'd3;
    settle();
    check("t1_rsp", {wr_rsp_valid, wr_rsp_id, wr_rsp_resp}, {1'b1, 4'd3, 2'd0});
    check("t1_bready_busy", bready, 1'b0);
    wr_rsp_ready = 1;
    clk1();
    wr_rsp_ready = 0;
    settle();
    check("t1_rsp_done", {wr_rsp_valid, wr_cmd_ready}, 2'b01);

    // ---- 4-beat write, wready toggling ----
    wr_cmd_valid = 1; wr_cmd_id = 4'd6; wr_cmd_addr = 32'h3000; wr_cmd_len = 4'd3;
    wr_cmd_size = 3'd2; wr_cmd_burst = 2'd1; awready = 1;
    clk1();
    wr_cmd_valid = 0;
    settle();
    check("t2_aw", {awvalid, awid, awaddr, awlen}, {1'b1, 4'd6, 32'h3000, 4'd3});
    clk1();
    awready = 0;
    settle();
    check("t2_aw_done", awvalid, 1'b0);
    hs = 0;
    beat = 0;
    for (int c = 0; c < 24 && hs < 4; c++) begin
      wready       = (c % 2 == 0);
      wr_dat_valid = (beat < 4);
      wr_dat_data  = (beat < 4) ? w4_data[beat] : 32'h0;
      wr_dat_strb  = 4'hF;
      settle();
      if (wvalid) check("t2_w_payload", {wlast, wdata}, {hs == 3, w4_data[hs]});
      if (wvalid && wready) hs++;
      if (wr_dat_valid && wr_dat_ready) beat++;
      clk1();
    end
    wr_dat_valid = 0;
    wready = 0;
    check("t2_w_count", hs, 4);
    check("t2_beats_taken", beat, 4);
    settle();
    check("t2_w_idle", {wvalid, bready}, 2'b01);
    clk1();
    settle();
    check("t2_no_extra", {wvalid, bready}, 2'b01);
    bvalid = 1; bid = 4'd6; bresp = 2'd2;
    clk1();
    bvalid = 0;
    settle();
    check("t2_rsp", {wr_rsp_valid, wr_rsp_id, wr_rsp_resp}, {1'b1, 4'd6, 2'd2});
    clk1();
    settle();
    check("t2_rsp_hold", {wr_rsp_valid, wr_rsp_id, wr_rsp_resp}, {1'b1, 4'd6, 2'd2});
    wr_rsp_ready = 1;
    clk1();
    wr_rsp_ready = 0;
    settle();
    check("t2_rsp_done", wr_rsp_valid, 1'b0);

    // ---- 8-beat read, user stalled 2 cycles ----
    rd_cmd_valid = 1; rd_cmd_id = 4'd5; rd_cmd_addr = 32'h2000; rd_cmd_len = 4'd7;
    rd_cmd_size = 3'd2; rd_cmd_burst = 2'd1;
    settle();
    check("t3_cmd_ready", rd_cmd_ready, 1'b1);
    clk1();
    rd_cmd_valid = 0; rd_cmd_addr = 32'h0; rd_cmd_id = 4'h0;
    settle();
    check("t3_ar", {arvalid, arid, araddr, arlen, arsize, arbrust},
          {1'b1, 4'd5, 32'h2000, 4'd7, 3'd2, 2'd1});
    check("t3_ar_const", {arlock, arcache, arprot, rd_cmd_ready}, 10'd0);
    clk1();
    settle();
    check("t3_ar_stable", {arvalid, arid, araddr, arlen}, {1'b1, 4'd5, 32'h2000, 4'd7});
    arready = 1;
    clk1();
    arready = 0;
    settle();
    check("t3_ar_done", arvalid, 1'b0);
    k = 0;
    for (int c = 0; c < 24 && k < 8; c++) begin
      rvalid = 1; rdata = 32'hA000_0000 + 32'(k); rid = 4'd5; rresp = 2'd0;
      rlast = (k == 7); rd_dat_ready = (c >= 2);
      settle();
      check("t3_r_pass", {rd_dat_valid, rready, rd_dat_last, rd_dat_id, rd_dat_data},
            {1'b1, c >= 2, k == 7, 4'd5, 32'hA000_0000 + 32'(k)});
      if (rd_dat_ready) k++;
      clk1();
    end
    rvalid = 1; rlast = 0; rd_dat_ready = 1;
    check("t3_r_count", k, 8);
    settle();
    check("t3_idle_gate", {rd_cmd_ready, rd_dat_valid, rready, len_err}, 4'b1000);
    rvalid = 0; rd_dat_ready = 0;

    // ---- Concurrent write (len=1) and read (len=1) ----
    wr_cmd_valid = 1; wr_cmd_id = 4'hA; wr_cmd_addr = 32'h4000; wr_cmd_len = 4'd1;
    wr_cmd_size = 3'd2; wr_cmd_burst = 2'd1;
    rd_cmd_valid = 1; rd_cmd_id = 4'd9; rd_cmd_addr = 32'h5000; rd_cmd_len = 4'd1;
    rd_cmd_size = 3'd2; rd_cmd_burst = 2'd1;
    awready = 1; arready = 1;
    settle();
    check("t4_both_ready", {wr_cmd_ready, rd_cmd_ready}, 2'b11);
    clk1();
    wr_cmd_valid = 0; rd_cmd_valid = 0;
    settle();
    check("t4_aw", {awvalid, awid, awaddr, awlen}, {1'b1, 4'hA, 32'h4000, 4'd1});
    check("t4_ar", {arvalid, arid, araddr, arlen}, {1'b1, 4'd9, 32'h5000, 4'd1});
    clk1();
    awready = 0; arready = 0;
    settle();
    check("t4_addr_done", {awvalid, arvalid, wr_cmd_ready, rd_cmd_ready}, 4'b0000);
    wready = 1; wr_dat_valid = 1; wr_dat_data = 32'h1111_1111; wr_dat_strb = 4'h3;
    rvalid = 1; rdata = 32'h0000_00B0; rid = 4'd9; rresp = 2'd0; rlast = 0; rd_dat_ready = 1;
    settle();
    check("t4_cA", {wr_dat_ready, wvalid, rd_dat_valid, rd_dat_last, rd_dat_data},
          {1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_00B0});
    clk1();
    wr_dat_data = 32'h2222_2222; wr_dat_strb = 4'hC;
    rdata = 32'h0000_00B1; rresp = 2'd1; rlast = 1;
    settle();
    check("t4_cB_w", {wr_dat_ready, wvalid, wlast, wstrob, wdata},
          {1'b1, 1'b1, 1'b0, 4'h3, 32'h1111_1111});
    check("t4_cB_r", {rd_dat_valid, rd_dat_last, rd_dat_resp, rd_dat_id, rd_dat_data},
          {1'b1, 1'b1, 2'd1, 4'd9, 32'h0000_00B1});
    clk1();
    wr_dat_valid = 0; rvalid = 0; rlast = 0;
    settle();
    check("t4_cC_w", {wvalid, wlast, wid, wstrob, wdata}, {1'b1, 1'b1, 4'hA, 4'hC, 32'h2222_2222});
    check("t4_rd_idle", rd_cmd_ready, 1'b1);
    clk1();
    wready = 0;
    settle();
    check("t4_w_done", {wvalid, bready}, 2'b01);
    bvalid = 1; bid = 4'hA; bresp = 2'd0;
    clk1();
    bvalid = 0;
    settle();
    check("t4_rsp", {wr_rsp_valid, wr_rsp_id, wr_rsp_resp}, {1'b1, 4'hA, 2'd0});
    wr_rsp_ready = 1;
    clk1();
    wr_rsp_ready = 0;
    settle();
    check("t4_done", {wr_rsp_valid, wr_cmd_ready, len_err}, 3'b010);

    // ---- Short read burst: len=3, rlast on beat 2 ----
    rd_cmd_valid = 1; rd_cmd_id = 4'd1; rd_cmd_addr = 32'h6000; rd_cmd_len = 4'd3;
    arready = 1;
    clk1();
    rd_cmd_valid = 0;
    clk1();
    arready = 0;
    settle();
    check("t5_ar_done", arvalid, 1'b0);
    rvalid = 1; rdata = 32'h0000_00C0; rid = 4'd1; rlast = 0; rd_dat_ready = 1;
    clk1();
    rdata = 32'h0000_00C1; rlast = 1;
    settle();
    check("t5_last_pass", {rd_dat_valid, rd_dat_last, len_err}, 3'b110);
    clk1();
    rvalid = 0; rlast = 0;
    settle();
    check("t5_len_err", len_err, EXP_LEN_ERR);
    check("t5_back_idle", rd_cmd_ready, 1'b1);
    // A clean single-beat read afterwards must not clear the flag.
    rd_cmd_valid = 1; rd_cmd_id = 4'd2; rd_cmd_len = 4'd0; arready = 1;
    clk1();
    rd_cmd_valid = 0;
    clk1();
    arready = 0;
    rvalid = 1; rid = 4'd2; rlast = 1;
    clk1();
    rvalid = 0; rlast = 0; rd_dat_ready = 0;
    clk1();
    settle();
    check("t5_sticky", {len_err, rd_cmd_ready}, {EXP_LEN_ERR, 1'b1});
    arst = 1;
    clk1();
    arst = 0;
    settle();
    check("t5_rst_clear", {len_err, awvalid, wvalid, arvalid, wr_rsp_valid}, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
